// File: rtl/zbt_arbiter.sv
// Single-port ZBT SRAM arbiter: buffered scan-point writes share the port with
// prioritised reads, using a starvation limit, LAT-deep write-data and read-tag pipelines.
module zbt_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int FIFO_DEPTH   = 4,
    parameter int LAT          = 2,
    parameter int STARVE_LIMIT = 8,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    output logic [CNT_W-1:0]  wr_count,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_n,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [SC_W-1:0]   r_starveCnt;

    logic [DATA_W-1:0] r_wPipeData [LAT];
    logic [LAT-1:0]    r_wPipeVld;
    logic [LAT:0]      r_rdTag;

    grant_t            w_grant;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    // Full is judged on the occupancy at cycle start, so a same-cycle pop never frees a slot.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push  = wr_req && !w_full;
    assign w_pop   = (w_grant == GRANT_WRITE);

    always_comb begin
        w_grant = GRANT_IDLE;
        if (rd_req && (w_empty || (r_starveCnt < SC_W'(STARVE_LIMIT)))) begin
            w_grant = GRANT_READ;
        end else if (!w_empty) begin
            w_grant = GRANT_WRITE;
        end
    end

    assign rd_ack      = (w_grant == GRANT_READ);
    assign wr_full     = w_full;
    assign wr_count    = r_count;
    assign wr_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr] <= wr_addr;
            r_fifoData[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (wr_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Counts reads that bypassed a waiting write; saturating keeps the write grant forced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starveCnt <= '0;
        end else if (w_empty || (w_grant == GRANT_WRITE)) begin
            r_starveCnt <= '0;
        end else if ((w_grant == GRANT_READ) && (r_starveCnt < SC_W'(STARVE_LIMIT))) begin
            r_starveCnt <= r_starveCnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            mem_we_n <= 1'b1;
        end else begin
            case (w_grant)
                GRANT_READ: begin
                    mem_addr <= rd_addr;
                    mem_we_n <= 1'b1;
                end
                GRANT_WRITE: begin
                    mem_addr <= r_fifoAddr[r_rdPtr];
                    mem_we_n <= 1'b0;
                end
                default: begin
                    mem_we_n <= 1'b1;
                end
            endcase
        end
    end

    // Stage 0 lines up with the address cycle; the output register lands LAT cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_wPipeData[i] <= '0;
            end
            r_wPipeVld   <= '0;
            mem_wdata    <= '0;
            mem_wdata_oe <= 1'b0;
        end else begin
            r_wPipeData[0] <= r_fifoData[r_rdPtr];
            r_wPipeVld[0]  <= w_pop;
            for (int i = 1; i < LAT; i++) begin
                r_wPipeData[i] <= r_wPipeData[i-1];
                r_wPipeVld[i]  <= r_wPipeVld[i-1];
            end
            mem_wdata_oe <= r_wPipeVld[LAT-1];
            if (r_wPipeVld[LAT-1]) begin
                mem_wdata <= r_wPipeData[LAT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdTag       <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            r_rdTag       <= {r_rdTag[LAT-1:0], (w_grant == GRANT_READ)};
            rd_data_valid <= r_rdTag[LAT];
            if (r_rdTag[LAT]) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_zbt_arbiter.sv
// Bench for zbt_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based model with a cycle-indexed schedule of expected bus events.
module tb_zbt_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 36;
    localparam int DEPTH  = 4;
    localparam int LAT    = 2;
    localparam int SL     = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_full;
    logic              wr_overflow;
    logic [2:0]        wr_count;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_n;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_oe;
    logic [DATA_W-1:0] mem_rdata = '0;

    zbt_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LAT(LAT), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_overflow(wr_overflow), .wr_count(wr_count),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .mem_addr(mem_addr), .mem_we_n(mem_we_n), .mem_wdata(mem_wdata),
        .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               fifoQ[$];
    bit                mOverflow;
    int                mStarve;
    bit                mAck;
    int                cyc;
    logic              expWeN;
    logic [ADDR_W-1:0] expAddr;
    bit                expOe[int];
    logic [DATA_W-1:0] expWd[int];
    bit                expRv[int];
    logic [DATA_W-1:0] rdBus[int];
    int                total = 0;
    int                bad = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic driveBus();
        logic [63:0] r;
        r = {$urandom, $urandom};
        mem_rdata = r[DATA_W-1:0];
        rdBus[cyc] = mem_rdata;
    endtask

    // One clock: check every output at the negedge, advance the model, then step past posedge.
    task automatic tick();
        bit   empty, fullNow, gRead, gWrite;
        wr_t  h;
        @(negedge clk);
        empty   = (fifoQ.size() == 0);
        fullNow = (fifoQ.size() == DEPTH);
        gRead   = rd_req && (empty || mStarve < SL);
        gWrite  = !gRead && !empty;
        checkOutput("wr_count", 64'(wr_count), 64'(fifoQ.size()));
        checkOutput("wr_full", 64'(wr_full), 64'(fullNow));
        checkOutput("wr_overflow", 64'(wr_overflow), 64'(mOverflow));
        checkOutput("rd_ack", 64'(rd_ack), 64'(gRead));
        checkOutput("mem_we_n", 64'(mem_we_n), 64'(expWeN));
        checkOutput("mem_addr", 64'(mem_addr), 64'(expAddr));
        checkOutput("mem_wdata_oe", 64'(mem_wdata_oe), 64'(expOe.exists(cyc)));
        if (expOe.exists(cyc)) checkOutput("mem_wdata", 64'(mem_wdata), 64'(expWd[cyc]));
        checkOutput("rd_data_valid", 64'(rd_data_valid), 64'(expRv.exists(cyc)));
        if (expRv.exists(cyc)) checkOutput("rd_data", 64'(rd_data), 64'(rdBus[cyc-1]));

        if (gRead) begin
            expAddr = rd_addr;
            expWeN  = 1'b1;
            expRv[cyc + LAT + 2] = 1'b1;
        end else if (gWrite) begin
            h = fifoQ.pop_front();
            expAddr = h.a;
            expWeN  = 1'b0;
            expOe[cyc + 1 + LAT] = 1'b1;
            expWd[cyc + 1 + LAT] = h.d;
        end else begin
            expWeN = 1'b1;
        end
        if (empty || gWrite) mStarve = 0;
        else if (gRead && mStarve < SL) mStarve++;
        if (wr_req) begin
            if (fullNow) mOverflow = 1'b1;
            else fifoQ.push_back('{a: wr_addr, d: wr_data});
        end
        mAck = gRead;

        @(posedge clk);
        #1;
        cyc++;
        driveBus();
    endtask

    task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input bit rd, input logic [ADDR_W-1:0] ra);
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rd;
        rd_addr = ra;
        tick();
    endtask

    task automatic doReset();
        reset   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        fifoQ.delete();
        mOverflow = 1'b0;
        mStarve = 0;
        mAck = 1'b0;
        expWeN = 1'b1;
        expAddr = '0;
        expOe.delete();
        expWd.delete();
        expRv.delete();
        rdBus.delete();
        driveBus();
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;

        // Reset, then idle.
        doReset();
        repeat (10) applyStimulus(0, '0, '0, 0, '0);

        // Single write drains through the address and data pipeline.
        applyStimulus(1, 19'h00005, 36'hABCDE, 0, '0);
        repeat (6) applyStimulus(0, '0, '0, 0, '0);

        // One read, then four back-to-back reads.
        applyStimulus(0, '0, '0, 1, 19'h7);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 1, 19'(16 + i));
        repeat (6) applyStimulus(0, '0, '0, 0, '0);

        // Continuous reads with one queued write: starvation limit forces the write through.
        ra = 19'h100;
        applyStimulus(1, 19'h00042, 36'h5A5A5, 1, ra);
        for (int i = 0; i < 14; i++) begin
            if (mAck) ra = ra + 19'd1;
            applyStimulus(0, '0, '0, 1, ra);
        end
        repeat (6) applyStimulus(0, '0, '0, 0, '0);

        // Five pushes while reads hold the port: fifth is dropped, overflow stays set.
        ra = 19'h200;
        for (int i = 0; i < 5; i++) begin
            if (mAck) ra = ra + 19'd1;
            applyStimulus(1, 19'(32 + i), 36'(36'h1000 + i), 1, ra);
        end
        for (int i = 0; i < 3; i++) begin
            if (mAck) ra = ra + 19'd1;
            applyStimulus(0, '0, '0, 1, ra);
        end
        repeat (12) applyStimulus(0, '0, '0, 0, '0);

        // Random traffic against the model.
        rd_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit wr;
            wr = ($urandom_range(0, 2) == 0);
            if (!rd_req || mAck) begin
                rd_req  = ($urandom_range(0, 3) != 0);
                rd_addr = 19'($urandom);
            end
            applyStimulus(wr, 19'($urandom), 36'({$urandom, $urandom}), rd_req, rd_addr);
        end
        repeat (12) applyStimulus(0, '0, '0, 0, '0);

        // Reset mid-read with a loaded FIFO: outputs clear asynchronously, no late strobe.
        applyStimulus(1, 19'h11, 36'h111, 1, 19'h300);
        applyStimulus(1, 19'h12, 36'h222, 1, 19'h301);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async mem_we_n", 64'(mem_we_n), 64'd1);
        checkOutput("async mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("async mem_wdata_oe", 64'(mem_wdata_oe), 64'd0);
        checkOutput("async mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("async rd_data_valid", 64'(rd_data_valid), 64'd0);
        checkOutput("async rd_data", 64'(rd_data), 64'd0);
        checkOutput("async wr_count", 64'(wr_count), 64'd0);
        checkOutput("async wr_full", 64'(wr_full), 64'd0);
        checkOutput("async wr_overflow", 64'(wr_overflow), 64'd0);
        doReset();
        repeat (8) applyStimulus(0, '0, '0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
